// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy states, the RISC-V NOP used
// as the IF/ID bubble, and the IF/ID payload width.
package pipe_pkg;

    // Occupancy of a skid stage: nothing held, main only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // addi x0, x0, 0: the canonical RISC-V NOP.
    localparam logic [31:0] RV_NOP = 32'h00000013;

    // IF/ID payload is {instr, pc, pcplus4}.
    localparam int unsigned IFID_W = 96;

    // Bubble for the IF/ID boundary: a NOP with zeroed pc fields.
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {RV_NOP, 64'h0};

    // True when the stage presents a real payload downstream.
    function automatic logic holds_payload(input state_t s);
        return (s != ST_EMPTY);
    endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, flush and a one-entry
// skid buffer. in_ready and out_data come straight from flops, so no
// combinational path crosses the stage in either direction.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W = IFID_W,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    state_t            state_reg;
    state_t            state_next;
    logic [DATA_W-1:0] main_reg;
    logic [DATA_W-1:0] main_next;
    logic [DATA_W-1:0] skid_reg;
    logic [DATA_W-1:0] skid_next;
    logic              in_ready_reg;
    logic              in_ready_next;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = holds_payload(state_reg);
    assign out_data  = main_reg;
    assign in_ready  = in_ready_reg;
    assign in_fire   = in_valid & in_ready_reg;
    assign out_fire  = out_valid & out_ready;

    // State, head payload and ready flag; reset empties the stage and
    // keeps in_ready low until the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_EMPTY;
            main_reg     <= BUBBLE;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            main_reg     <= main_next;
            in_ready_reg <= in_ready_next;
        end
    end

    // Skid contents are only meaningful in ST_FULL, so they need no reset.
    always_ff @(posedge clk) begin
        skid_reg <= skid_next;
    end

    // Next occupancy; flush squashes everything and drops any input.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) state_next = ST_BUSY;
                end
                ST_BUSY: begin
                    if (in_fire && !out_ready)      state_next = ST_FULL;
                    else if (!in_fire && out_fire)  state_next = ST_EMPTY;
                end
                ST_FULL: begin
                    if (out_fire) state_next = ST_BUSY;
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Payload movement and registered ready: ready stays high unless the
    // stage is about to hold two payloads.
    always_comb begin
        main_next     = main_reg;
        skid_next     = skid_reg;
        in_ready_next = (state_next != ST_FULL);
        if (flush) begin
            main_next = BUBBLE;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) main_next = in_data;
                end
                ST_BUSY: begin
                    if (in_fire && out_fire)  main_next = in_data;
                    else if (in_fire)         skid_next = in_data;
                    else if (out_fire)        main_next = BUBBLE;
                end
                ST_FULL: begin
                    if (out_fire) main_next = skid_reg;
                end
                default: main_next = BUBBLE;
            endcase
        end
    end

endmodule
